// File: rtl/uop_seq_if.sv
// Micro-op issue channel between the sequencer and the modular execution unit.
//   uop_valid  : micro-op valid (sequencer -> executor)
//   uop_opcode : issued opcode
//   uop_src_a  : issued source A
//   uop_src_b  : issued source B
//   uop_dst    : issued destination
//   uop_ready  : executor has completed the micro-op (executor -> sequencer)
//   exec_flag  : result of the last completed CMP (executor -> sequencer)
interface uop_seq_if #(
  parameter int unsigned OPC_W = 4,
  parameter int unsigned SRC_W = 5,
  parameter int unsigned DST_W = 4
);
  logic             uop_valid;
  logic [OPC_W-1:0] uop_opcode;
  logic [SRC_W-1:0] uop_src_a;
  logic [SRC_W-1:0] uop_src_b;
  logic [DST_W-1:0] uop_dst;
  logic             uop_ready;
  logic             exec_flag;

  modport master (
    output uop_valid, uop_opcode, uop_src_a, uop_src_b, uop_dst,
    input  uop_ready, exec_flag
  );

  modport slave (
    input  uop_valid, uop_opcode, uop_src_a, uop_src_b, uop_dst,
    output uop_ready, exec_flag
  );
endinterface

// File: rtl/uop_seq.sv
// Microprogram sequencer for the curve arithmetic engine. Walks a synchronous microcode ROM
// (1-cycle read latency) from a selectable entry point, issues each micro-op over a
// valid/ready handshake, skips conditional micro-ops on the comparison flag and stops on the
// RDY opcode.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_ena        : start request, sampled only while idle
//   i_prog_sel   : program index, sampled with i_ena
//   o_rdy        : high when idle
//   o_err        : sticky error (bad program index / length or address overrun)
//   o_rom_addr   : registered ROM address
//   i_rom_data   : ROM word {opcode, src_a, src_b, dst, exec}, valid one cycle after address
//   uop_if       : micro-op issue channel (master side)
module uop_seq #(
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned OPC_W     = 4,
  parameter int unsigned SRC_W     = 5,
  parameter int unsigned DST_W     = 4,
  parameter int unsigned EXC_W     = 2,
  parameter int unsigned NUM_PROGS = 4,
  parameter logic [NUM_PROGS*ADDR_W-1:0] PROG_BASE = {6'd48, 6'd32, 6'd16, 6'd0},
  parameter int unsigned MAX_LEN   = 32,
  parameter logic [OPC_W-1:0] OPCODE_RDY = '0
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst,
  input  logic                                    i_ena,
  // One spare code point so an out-of-range index is representable and reaches the error path.
  input  logic [$clog2(NUM_PROGS+1)-1:0]          i_prog_sel,
  output logic                                    o_rdy,
  output logic                                    o_err,
  output logic [ADDR_W-1:0]                       o_rom_addr,
  input  logic [OPC_W+2*SRC_W+DST_W+EXC_W-1:0]    i_rom_data,
  uop_seq_if.master                               uop_if
);

  localparam int unsigned PSEL_W = $clog2(NUM_PROGS + 1);
  localparam int unsigned CNT_W  = $clog2(MAX_LEN + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_DECODE = 2'd2;
  localparam logic [1:0] ST_ISSUE  = 2'd3;

  logic [1:0]        r_state,   w_state_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [CNT_W-1:0]  r_count,   w_count_nxt;
  logic              r_err,     w_err_nxt;
  logic              r_rdy,     w_rdy_nxt;
  logic              r_valid,   w_valid_nxt;
  logic [OPC_W-1:0]  r_opc,     w_opc_nxt;
  logic [SRC_W-1:0]  r_src_a,   w_src_a_nxt;
  logic [SRC_W-1:0]  r_src_b,   w_src_b_nxt;
  logic [DST_W-1:0]  r_dst,     w_dst_nxt;

  // ROM word fields
  logic [OPC_W-1:0]  w_opc;
  logic [SRC_W-1:0]  w_src_a;
  logic [SRC_W-1:0]  w_src_b;
  logic [DST_W-1:0]  w_dst;
  logic [EXC_W-1:0]  w_exec;

  assign w_exec  = i_rom_data[0 +: EXC_W];
  assign w_dst   = i_rom_data[EXC_W +: DST_W];
  assign w_src_b = i_rom_data[EXC_W+DST_W +: SRC_W];
  assign w_src_a = i_rom_data[EXC_W+DST_W+SRC_W +: SRC_W];
  assign w_opc   = i_rom_data[EXC_W+DST_W+2*SRC_W +: OPC_W];

  logic              w_sel_ok;
  logic [ADDR_W-1:0] w_base;
  logic              w_exec_ok;
  logic              w_advance;
  logic [CNT_W-1:0]  w_count_inc;

  assign w_sel_ok    = (32'(i_prog_sel) < NUM_PROGS);
  assign w_count_inc = r_count + 1'b1;

  // Entry-point mux; an out-of-range index selects nothing and is rejected in IDLE.
  always_comb begin
    w_base = '0;
    for (int unsigned p = 0; p < NUM_PROGS; p++) begin
      if (i_prog_sel == PSEL_W'(p)) begin
        w_base = PROG_BASE[p*ADDR_W +: ADDR_W];
      end
    end
  end

  // Exec condition: 0 always, 1 flag set, 2 flag clear, 3 never (NOP skip).
  always_comb begin
    w_exec_ok = 1'b0;
    if (w_exec == EXC_W'(0)) begin
      w_exec_ok = 1'b1;
    end else if (w_exec == EXC_W'(1)) begin
      w_exec_ok = uop_if.exec_flag;
    end else if (w_exec == EXC_W'(2)) begin
      w_exec_ok = ~uop_if.exec_flag;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    w_rdy_nxt   = r_rdy;
    w_valid_nxt = r_valid;
    w_opc_nxt   = r_opc;
    w_src_a_nxt = r_src_a;
    w_src_b_nxt = r_src_b;
    w_dst_nxt   = r_dst;
    w_advance   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_ena) begin
          if (w_sel_ok) begin
            w_addr_nxt  = w_base;
            w_count_nxt = '0;
            w_err_nxt   = 1'b0;
            w_rdy_nxt   = 1'b0;
            w_state_nxt = ST_WAIT;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (w_opc == OPCODE_RDY) begin
          w_rdy_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (w_exec_ok) begin
          w_opc_nxt   = w_opc;
          w_src_a_nxt = w_src_a;
          w_src_b_nxt = w_src_b;
          w_dst_nxt   = w_dst;
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_advance = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (uop_if.uop_ready) begin
          w_valid_nxt = 1'b0;
          w_advance   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Length or address overrun aborts the program; the address never wraps.
    if (w_advance) begin
      if ((32'(w_count_inc) == MAX_LEN) || (&r_addr)) begin
        w_err_nxt   = 1'b1;
        w_rdy_nxt   = 1'b1;
        w_state_nxt = ST_IDLE;
      end else begin
        w_count_nxt = w_count_inc;
        w_addr_nxt  = r_addr + 1'b1;
        w_state_nxt = ST_WAIT;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_rdy   <= 1'b1;
      r_valid <= 1'b0;
      r_opc   <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_rdy   <= w_rdy_nxt;
      r_valid <= w_valid_nxt;
      r_opc   <= w_opc_nxt;
      r_src_a <= w_src_a_nxt;
      r_src_b <= w_src_b_nxt;
      r_dst   <= w_dst_nxt;
    end
  end

  assign o_rdy             = r_rdy;
  assign o_err             = r_err;
  assign o_rom_addr        = r_addr;
  assign uop_if.uop_valid  = r_valid;
  assign uop_if.uop_opcode = r_opc;
  assign uop_if.uop_src_a  = r_src_a;
  assign uop_if.uop_src_b  = r_src_b;
  assign uop_if.uop_dst    = r_dst;

endmodule

// File: tb/tb_uop_seq.sv
// Self-checking bench for uop_seq: ROM and executor models, a scoreboard of expected
// micro-ops, a vector table of program runs and hand-written reset / out-of-range sequences.
module tb_uop_seq;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_ena;
  logic [2:0]  i_prog_sel;
  logic        o_rdy;
  logic        o_err;
  logic [5:0]  o_rom_addr;
  logic [19:0] rom_data;

  uop_seq_if #(.OPC_W(4), .SRC_W(5), .DST_W(4)) bus ();

  uop_seq dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_ena      (i_ena),
    .i_prog_sel (i_prog_sel),
    .o_rdy      (o_rdy),
    .o_err      (o_err),
    .o_rom_addr (o_rom_addr),
    .i_rom_data (rom_data),
    .uop_if     (bus)
  );

  always #5 clk = ~clk;

  // Synchronous ROM model, 1-cycle latency
  logic [19:0] rom [64];
  always @(posedge clk) rom_data <= rom[o_rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [19:0] uop(input int opc, input int sa, input int sb, input int d,
                                      input int e);
    return {4'(opc), 5'(sa), 5'(sb), 4'(d), 2'(e)};
  endfunction

  // Scoreboard entry: {rom_addr, opcode, src_a, src_b, dst}
  logic [23:0] exp_q[$];

  // Executor model / monitor
  int   ready_delay = 0;
  logic ready_idle  = 1'b0;
  int   vcnt = 0;
  int   hs_cnt = 0;
  int   valid_cycles = 0;
  bit   rise_seen = 0;
  int   rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic [23:0] act_uop;

  always @(negedge clk) begin
    if (i_rst) begin
      bus.uop_ready = 1'b0;
      vcnt = 0;
      prev_valid = 1'b0;
    end else begin
      if (bus.uop_valid) begin
        valid_cycles++;
        if (!prev_valid && !rise_seen) begin
          rise_seen = 1;
          rise_cyc  = cyc;
        end
        act_uop = {o_rom_addr, bus.uop_opcode, bus.uop_src_a, bus.uop_src_b, bus.uop_dst};
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_uop: got %0h expected none", act_uop);
        end else begin
          check("uop_fields", 64'(act_uop), 64'(exp_q[0]));
        end
        if (vcnt >= ready_delay) begin
          bus.uop_ready = 1'b1;
          hs_cnt++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          vcnt = 0;
        end else begin
          bus.uop_ready = 1'b0;
          vcnt++;
        end
      end else begin
        bus.uop_ready = ready_idle;
        vcnt = 0;
      end
      prev_valid = bus.uop_valid;
    end
  end

  // ROM images: 0 = programs with RDY (base 48 has none), 1 = no RDY anywhere
  task automatic load_img(input int img);
    for (int a = 0; a < 64; a++) begin
      rom[a] = (img == 1) ? uop(4, a % 32, 1, a % 16, 3) : 20'h0;
    end
    if (img == 0) begin
      rom[0]  = uop(1, 1, 2, 3, 0);    // ADD
      rom[1]  = uop(2, 4, 5, 6, 0);    // MUL
      rom[16] = uop(7, 1, 2, 0, 0);    // CMP
      rom[17] = uop(5, 3, 0, 4, 2);    // MOV if !flag
      rom[18] = uop(5, 4, 0, 5, 2);
      rom[19] = uop(5, 5, 0, 6, 2);
      rom[32] = uop(3, 7, 8, 9, 0);    // SUB
      rom[33] = uop(1, 10, 11, 12, 1); // ADD if flag
      rom[34] = uop(9, 13, 0, 14, 3);  // never
      for (int a = 48; a < 64; a++) rom[a] = uop(6, a - 48, 0, a % 16, (a == 48) ? 0 : 3);
    end
  endtask

  // Expected issue list from ROM contents and flag
  task automatic build_exp(input int sel, input logic flag);
    int  addr;
    logic [19:0] w;
    bit  go;
    exp_q.delete();
    addr = sel * 16;
    go   = 1;
    for (int k = 0; k < 32 && go; k++) begin
      w = rom[addr];
      if (w[19:16] == 4'd0) begin
        go = 0;
      end else begin
        if (w[1:0] == 2'd0 || (w[1:0] == 2'd1 && flag) || (w[1:0] == 2'd2 && !flag))
          exp_q.push_back({6'(addr), w[19:2]});
        if (addr == 63) go = 0;
        else addr++;
      end
    end
  endtask

  typedef struct {
    int   img;
    int   sel;
    logic flag;
    int   delay;
    logic rdy_idle;
    int   pulse_edge;   // 0 = no busy ena pulse
    int   pulse_sel;
    logic exp_err;
    int   exp_issued;
    int   exp_cycles;   // accept edge to rdy=1
    int   exp_addr;     // final rom_addr
    int   exp_first;    // first valid offset, -1 = not checked
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int i);
    vec_t v;
    int   n;
    int   acc;
    bit   done;
    v = vecs[i];
    load_img(v.img);
    build_exp(v.sel, v.flag);
    bus.exec_flag = v.flag;
    ready_delay   = v.delay;
    ready_idle    = v.rdy_idle;
    hs_cnt        = 0;
    valid_cycles  = 0;
    rise_seen     = 0;
    @(negedge clk);
    i_ena      = 1'b1;
    i_prog_sel = 3'(v.sel);
    @(posedge clk);
    #1;
    acc   = cyc;
    i_ena = 1'b0;
    n     = 0;
    done  = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      if (n == 0) begin
        check($sformatf("v%0d_busy_rdy", i), 64'(o_rdy), 64'(0));
        check($sformatf("v%0d_err_clear", i), 64'(o_err), 64'(0));
      end else if (o_rdy) begin
        done = 1;
      end
      if (!done) begin
        i_ena      = (n + 1 == v.pulse_edge);
        i_prog_sel = 3'(v.pulse_sel);
        @(posedge clk);
        n++;
      end
    end
    i_ena = 1'b0;
    check($sformatf("v%0d_finished", i), 64'(done), 64'(1));
    check($sformatf("v%0d_cycles", i), 64'(n), 64'(v.exp_cycles));
    check($sformatf("v%0d_err", i), 64'(o_err), 64'(v.exp_err));
    check($sformatf("v%0d_addr", i), 64'(o_rom_addr), 64'(v.exp_addr));
    check($sformatf("v%0d_issued", i), 64'(hs_cnt), 64'(v.exp_issued));
    check($sformatf("v%0d_valid_cycles", i), 64'(valid_cycles),
          64'(v.exp_issued * (v.delay + 1)));
    check($sformatf("v%0d_drained", i), 64'(exp_q.size()), 64'(0));
    if (v.exp_first >= 0)
      check($sformatf("v%0d_first_valid", i), 64'(rise_cyc - acc), 64'(v.exp_first));
    @(posedge clk);
    @(negedge clk);
    check($sformatf("v%0d_rdy_hold", i), 64'(o_rdy), 64'(1));
    check($sformatf("v%0d_addr_hold", i), 64'(o_rom_addr), 64'(v.exp_addr));
  endtask

  initial begin
    logic [5:0] addr_before;
    bit         seen;

    //         img sel flag dly idle pe ps  err iss cyc addr first
    vecs[0] = '{0, 0, 1'b0, 0, 1'b1, 0, 0, 1'b0, 2, 8,  2,  2};
    vecs[1] = '{0, 2, 1'b0, 5, 1'b0, 0, 0, 1'b0, 1, 14, 35, 2};
    vecs[2] = '{0, 1, 1'b1, 0, 1'b0, 0, 0, 1'b0, 1, 11, 20, -1};
    vecs[3] = '{0, 1, 1'b0, 0, 1'b1, 0, 0, 1'b0, 4, 14, 20, -1};
    vecs[4] = '{0, 3, 1'b0, 0, 1'b0, 0, 0, 1'b1, 1, 33, 63, -1};
    vecs[5] = '{1, 0, 1'b0, 0, 1'b0, 0, 0, 1'b1, 0, 64, 31, -1};
    vecs[6] = '{0, 0, 1'b0, 0, 1'b0, 4, 1, 1'b0, 2, 8,  2,  -1};
    vecs[7] = '{0, 2, 1'b1, 2, 1'b1, 14, 0, 1'b0, 2, 14, 35, -1};

    i_rst         = 1'b1;
    i_ena         = 1'b0;
    i_prog_sel    = '0;
    bus.exec_flag = 1'b0;
    bus.uop_ready = 1'b0;
    load_img(0);
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    @(negedge clk);
    check("reset_rdy", 64'(o_rdy), 64'(1));
    check("reset_err", 64'(o_err), 64'(0));
    check("reset_valid", 64'(bus.uop_valid), 64'(0));
    check("reset_addr", 64'(o_rom_addr), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(i);

    // Out-of-range program index: error, no fetch
    @(negedge clk);
    addr_before = o_rom_addr;
    i_ena       = 1'b1;
    i_prog_sel  = 3'd4;
    @(posedge clk);
    #1;
    i_ena = 1'b0;
    @(negedge clk);
    check("oor_err", 64'(o_err), 64'(1));
    check("oor_rdy", 64'(o_rdy), 64'(1));
    check("oor_addr", 64'(o_rom_addr), 64'(addr_before));
    @(negedge clk);
    check("oor_no_valid", 64'(bus.uop_valid), 64'(0));
    check("oor_still_idle", 64'(o_rdy), 64'(1));
    run_vec(1);  // accepted ena clears the error

    // Reset while a micro-op is held in ISSUE
    load_img(0);
    build_exp(2, 1'b0);
    bus.exec_flag = 1'b0;
    ready_delay   = 50;
    ready_idle    = 1'b0;
    @(negedge clk);
    i_ena      = 1'b1;
    i_prog_sel = 3'd2;
    @(posedge clk);
    #1;
    i_ena = 1'b0;
    seen  = 0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.uop_valid) seen = 1;
    end
    check("rst_issue_reached", 64'(seen), 64'(1));
    @(negedge clk);
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", 64'(bus.uop_valid), 64'(0));
    check("rst_rdy", 64'(o_rdy), 64'(1));
    check("rst_addr", 64'(o_rom_addr), 64'(0));
    check("rst_err", 64'(o_err), 64'(0));
    check("rst_fields", 64'({bus.uop_opcode, bus.uop_src_a, bus.uop_src_b, bus.uop_dst}),
          64'(0));
    i_rst = 1'b0;
    exp_q.delete();
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
